// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter and its datapath.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // ALU control codes; the flag is carry-in for ADD/SUB and fill bit for shifts.
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOTA  = 4'h5;
    localparam logic [3:0] OP_PASSA = 4'h6;
    localparam logic [3:0] OP_PASSB = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU. Shifts move by i_b positions, filling with i_flag;
// carry is the last bit shifted out. Unused control codes yield zero.
module alu_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic [3:0]   i_ctrl,
    input  logic         i_flag,
    output logic [n-1:0] o_result,
    output logic         o_c,
    output logic         o_z
);

    logic [n:0]   w_sum;
    logic [n-1:0] w_res;
    logic         w_c;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        case (i_ctrl)
            OP_ADD: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b} + {{n{1'b0}}, i_flag};
                w_res = w_sum[n-1:0];
                w_c   = w_sum[n];
            end
            OP_SUB: begin
                w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{n{1'b0}}, i_flag};
                w_res = w_sum[n-1:0];
                w_c   = w_sum[n];
            end
            OP_AND:   w_res = i_a & i_b;
            OP_OR:    w_res = i_a | i_b;
            OP_XOR:   w_res = i_a ^ i_b;
            OP_NOTA:  w_res = ~i_a;
            OP_PASSA: w_res = i_a;
            OP_PASSB: w_res = i_b;
            OP_SHL: begin
                w_res = i_a;
                for (int unsigned i = 0; i < n; i++) begin
                    if (i < 32'(i_b)) begin
                        w_c   = w_res[n-1];
                        w_res = {w_res[n-2:0], i_flag};
                    end
                end
            end
            OP_SHR: begin
                w_res = i_a;
                for (int unsigned i = 0; i < n; i++) begin
                    if (i < 32'(i_b)) begin
                        w_c   = w_res[0];
                        w_res = {i_flag, w_res[n-1:1]};
                    end
                end
            end
            default: begin
                w_res = '0;
                w_c   = 1'b0;
            end
        endcase
    end

    assign o_result = w_res;
    assign o_c      = w_c;
    assign o_z      = (w_res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU: accept one operation,
// execute it for a cycle, then hold the registered response for its owner.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic [3:0]   req0_ctrl,
    input  logic         req0_flag,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    input  logic [3:0]   req1_ctrl,
    input  logic         req1_flag,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    input  logic         rsp0_ready,
    input  logic         rsp1_ready,
    output logic [n-1:0] rsp_result,
    output logic         rsp_c,
    output logic         rsp_z,
    output logic         busy
);

    state_t       r_state;
    state_t       w_next_state;
    logic         r_last;
    logic         r_owner;
    logic [n-1:0] r_a;
    logic [n-1:0] r_b;
    logic [3:0]   r_ctrl;
    logic         r_flag;
    logic [n-1:0] r_result;
    logic         r_c;
    logic         r_z;

    logic         w_any_valid;
    logic         w_grant_id;
    logic         w_accept;
    logic         w_rsp_done;
    logic [n-1:0] w_alu_result;
    logic         w_alu_c;
    logic         w_alu_z;

    assign w_any_valid = req0_valid | req1_valid;
    assign w_accept    = (r_state == IDLE) && w_any_valid;
    assign w_rsp_done  = (r_state == RESP) &&
                         ((r_owner == REQ0) ? rsp0_ready : rsp1_ready);

    // On a tie the requester not granted last wins; a lone requester always wins.
    always_comb begin
        w_grant_id = REQ0;
        if (req0_valid && req1_valid) begin
            w_grant_id = (r_last == REQ0) ? REQ1 : REQ0;
        end else if (req1_valid) begin
            w_grant_id = REQ1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_valid) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (w_rsp_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted, even before the
    // synchronous reset has taken effect on the state register.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        if (rst_n) begin
            busy = (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    req0_ready = w_any_valid && (w_grant_id == REQ0);
                    req1_ready = w_any_valid && (w_grant_id == REQ1);
                end
                RESP: begin
                    rsp0_valid = (r_owner == REQ0);
                    rsp1_valid = (r_owner == REQ1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last   <= REQ1;
            r_owner  <= REQ0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= '0;
            r_flag   <= 1'b0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last  <= w_grant_id;
                r_owner <= w_grant_id;
                r_a     <= (w_grant_id == REQ1) ? req1_a    : req0_a;
                r_b     <= (w_grant_id == REQ1) ? req1_b    : req0_b;
                r_ctrl  <= (w_grant_id == REQ1) ? req1_ctrl : req0_ctrl;
                r_flag  <= (w_grant_id == REQ1) ? req1_flag : req0_flag;
            end
            if (r_state == EXEC) begin
                r_result <= w_alu_result;
                r_c      <= w_alu_c;
                r_z      <= w_alu_z;
            end
        end
    end

    alu_arbiter_alu #(.n(n)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_ctrl   (r_ctrl),
        .i_flag   (r_flag),
        .o_result (w_alu_result),
        .o_c      (w_alu_c),
        .o_z      (w_alu_z)
    );

    assign rsp_result = r_result;
    assign rsp_c      = r_c;
    assign rsp_z      = r_z;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, tie-break, fairness, a table of ALU
// operations, response backpressure and reset during execution.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_flag;
    logic [3:0] req0_a, req0_b, req0_ctrl;
    logic       req1_valid, req1_ready, req1_flag;
    logic [3:0] req1_a, req1_b, req1_ctrl;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [3:0] rsp_result;
    logic       rsp_c, rsp_z, busy;

    int n_checks = 0;
    int n_errors = 0;
    int grants[$];

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ctrl;
        logic       flag;
        logic [3:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs[15];

    alu_arbiter #(.n(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req0_flag  (req0_flag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .req1_flag  (req1_flag),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_c      (rsp_c),
        .rsp_z      (rsp_z),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        if (v.id) begin
            req1_a = v.a; req1_b = v.b; req1_ctrl = v.ctrl; req1_flag = v.flag; req1_valid = 1'b1;
        end else begin
            req0_a = v.a; req0_b = v.b; req0_ctrl = v.ctrl; req0_flag = v.flag; req0_valid = 1'b1;
        end
        #1;
        chk("op_ready_own",   v.id ? req1_ready : req0_ready, 1);
        chk("op_ready_other", v.id ? req0_ready : req1_ready, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("op_exec_busy",  busy, 1);
        chk("op_exec_rsp",   v.id ? rsp1_valid : rsp0_valid, 0);
        step();
        chk("op_rsp_own",    v.id ? rsp1_valid : rsp0_valid, 1);
        chk("op_rsp_other",  v.id ? rsp0_valid : rsp1_valid, 0);
        chk("op_result",     rsp_result, v.res);
        chk("op_c",          rsp_c, v.c);
        chk("op_z",          rsp_z, v.z);
        if (v.id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        chk("op_done_busy",  busy, 0);
    endtask

    initial begin
        //           id    a        b        ctrl  flag  res      c     z
        vecs[0]  = '{1'b0, 4'b0110, 4'b0010, 4'h8, 1'b0, 4'b1000, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'b0011, 4'b0100, 4'h0, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 4'b0111, 4'b0111, 4'h0, 1'b1, 4'b1111, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0101, 4'b0011, 4'h1, 1'b1, 4'b0010, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'b0011, 4'b0101, 4'h1, 1'b1, 4'b1110, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b1100, 4'b1010, 4'h2, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'b1100, 4'b0011, 4'h3, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b1010, 4'b1010, 4'h4, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 4'b0110, 4'b0000, 4'h8, 1'b1, 4'b0110, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b1001, 4'b0100, 4'h8, 1'b0, 4'b0000, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 4'b1000, 4'b0001, 4'h9, 1'b1, 4'b1100, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b0110, 4'b0010, 4'h9, 1'b0, 4'b0001, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'b0101, 4'b0000, 4'h5, 1'b0, 4'b1010, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b0011, 4'b1100, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b1};

        rst_n = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_flag = 1'b0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_flag = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step();
        step();
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_busy",       busy, 0);
        chk("rst_result",     rsp_result, 0);
        chk("rst_c",          rsp_c, 0);
        chk("rst_z",          rsp_z, 0);

        // First tie after reset goes to requester 0, then requester 1 is served.
        req0_a = 4'b0110; req0_b = 4'b0010; req0_ctrl = 4'h9; req0_flag = 1'b0;
        req1_a = 4'b0110; req1_b = 4'b0010; req1_ctrl = 4'h8; req1_flag = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("tie_req0_ready", req0_ready, 1);
        chk("tie_req1_ready", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("tie_exec_req1_ready", req1_ready, 0);
        chk("tie_exec_busy",       busy, 1);
        chk("tie_exec_rsp0",       rsp0_valid, 0);
        step();
        chk("tie_rsp0_valid", rsp0_valid, 1);
        chk("tie_rsp1_valid", rsp1_valid, 0);
        chk("tie_res0",       rsp_result, 4'b0001);
        chk("tie_c0",         rsp_c, 1);
        chk("tie_resp_req1_ready", req1_ready, 0);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        #1;
        chk("tie2_req1_ready", req1_ready, 1);
        chk("tie2_req0_ready", req0_ready, 0);
        step();
        req1_valid = 1'b0;
        step();
        chk("tie2_rsp1_valid", rsp1_valid, 1);
        chk("tie2_rsp0_valid", rsp0_valid, 0);
        chk("tie2_res1",       rsp_result, 4'b1011);
        chk("tie2_c1",         rsp_c, 1);
        chk("tie2_z1",         rsp_z, 0);
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        #1;
        chk("tie2_done_busy", busy, 0);

        // Both requesters valid continuously: grants must alternate.
        req0_a = 4'd1; req0_b = 4'd1; req0_ctrl = 4'h0; req0_flag = 1'b0;
        req1_a = 4'd2; req1_b = 4'd2; req1_ctrl = 4'h0; req1_flag = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && grants.size() < 6; cyc++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("fair_count", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++) begin
            chk($sformatf("fair_grant%0d", i), grants[i], i % 2);
        end
        for (int k = 0; k < 10 && busy; k++) step();
        chk("fair_drain_busy", busy, 0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Owner stalls its response; the other requester must stay locked out.
        req0_a = 4'd3; req0_b = 4'd4; req0_ctrl = 4'h0; req0_flag = 1'b0;
        req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0; req1_valid = 1'b1; rsp1_ready = 1'b1; rsp0_ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp0_valid",  rsp0_valid, 1);
            chk("bp_result",      rsp_result, 4'b0111);
            chk("bp_req1_ready",  req1_ready, 0);
            chk("bp_busy",        busy, 1);
            step();
        end
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        #1;
        chk("bp_next_req1_ready", req1_ready, 1);
        chk("bp_next_rsp0_valid", rsp0_valid, 0);
        req1_valid = 1'b0; rsp1_ready = 1'b0;
        #1;

        // Reset during EXEC after a requester-0 grant: op dropped, pointer back to favour 0.
        req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("mid_rst_result", rsp_result, 0);
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_rsp0", rsp0_valid, 0);
            chk("mid_rst_rsp1", rsp1_valid, 0);
            chk("mid_rst_busy", busy, 0);
            step();
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_rst_tie_req0", req0_ready, 1);
        chk("mid_rst_tie_req1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
